hir_vec_add: RTL and testbench

- Streaming element-wise vector adder, equivalent to HIR-generated `Add`: C[i] = A[i] + B[i] for i = 0..N-1.
- Reads operands from two external single-port read memories (ports 0, 1) and writes results to an external write memory (port 2).
- Triggered by a one-cycle start pulse; processes one element per cycle (II = 1).
- Sits between HIR-lowered memory wrappers; owns no storage beyond its pipeline registers.

---
 rtl/hir_vec_add.sv | 130 +++++++++++++
 tb/tb_hir_vec_add.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hir_vec_add.sv
// ============================================================================
// Module   : hir_vec_add
// Purpose  : Streaming element-wise adder C[i] = A[i] + B[i], one element per
//            cycle, reading two 1-cycle-latency memories and writing a third.
//            Build option HIR_VEC_ADD_SIGNED_EN selects sign-extended operands.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module hir_vec_add #(
    parameter int N      = 128,
    parameter int ADDR_W = 7,
    parameter int DATA_W = 32,
    parameter int OUT_W  = 64
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              t3,
    output logic [ADDR_W-1:0] v_addr0,
    output logic              v_rd_en0,
    input  logic [DATA_W-1:0] v_rd_data0,
    output logic [ADDR_W-1:0] v_addr1,
    output logic              v_rd_en1,
    input  logic [DATA_W-1:0] v_rd_data1,
    output logic [ADDR_W-1:0] v_addr2,
    output logic              v_wr_en2,
    output logic [OUT_W-1:0]  v_wr_data2,
    output logic              done
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_DRAIN = 2'd2;

    localparam logic [ADDR_W-1:0] c_LAST = ADDR_W'(N - 1);

    logic [1:0]        r_state;
    logic              r_rd_en;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_cap_vld;
    logic [ADDR_W-1:0] r_cap_addr;
    logic              r_wr_en;
    logic [ADDR_W-1:0] r_wr_addr;
    logic [OUT_W-1:0]  r_wr_data;
    logic              r_done;

    logic [OUT_W-1:0]  w_op_a;
    logic [OUT_W-1:0]  w_op_b;
    logic [OUT_W-1:0]  w_sum;

`ifdef HIR_VEC_ADD_SIGNED_EN
    assign w_op_a = {{(OUT_W-DATA_W){v_rd_data0[DATA_W-1]}}, v_rd_data0};
    assign w_op_b = {{(OUT_W-DATA_W){v_rd_data1[DATA_W-1]}}, v_rd_data1};
`else
    assign w_op_a = {{(OUT_W-DATA_W){1'b0}}, v_rd_data0};
    assign w_op_b = {{(OUT_W-DATA_W){1'b0}}, v_rd_data1};
`endif

    // OUT_W > DATA_W, so the sum never wraps in either build.
    assign w_sum = w_op_a + w_op_b;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_ST_IDLE;
            r_rd_en    <= 1'b0;
            r_rd_addr  <= '0;
            r_cap_vld  <= 1'b0;
            r_cap_addr <= '0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            // Read data arrives the cycle after the request; sum it then.
            r_cap_vld <= r_rd_en;
            if (r_rd_en) begin
                r_cap_addr <= r_rd_addr;
            end

            r_wr_en <= r_cap_vld;
            if (r_cap_vld) begin
                r_wr_addr <= r_cap_addr;
                r_wr_data <= w_sum;
            end

            case (r_state)
                c_ST_IDLE: begin
                    if (t3) begin
                        r_state   <= c_ST_READ;
                        r_rd_en   <= 1'b1;
                        r_rd_addr <= '0;
                    end
                end
                c_ST_READ: begin
                    if (r_rd_addr == c_LAST) begin
                        r_rd_en <= 1'b0;
                        r_state <= c_ST_DRAIN;
                    end else begin
                        r_rd_addr <= r_rd_addr + ADDR_W'(1);
                    end
                end
                c_ST_DRAIN: begin
                    // Going idle here lets a start be taken in the done cycle.
                    if (r_wr_en && (r_wr_addr == c_LAST)) begin
                        r_done  <= 1'b1;
                        r_state <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    r_rd_en <= 1'b0;
                end
            endcase
        end
    end

    assign v_addr0    = r_rd_addr;
    assign v_addr1    = r_rd_addr;
    assign v_rd_en0   = r_rd_en;
    assign v_rd_en1   = r_rd_en;
    assign v_addr2    = r_wr_addr;
    assign v_wr_en2   = r_wr_en;
    assign v_wr_data2 = r_wr_data;
    assign done       = r_done;

endmodule

`default_nettype wire

// File: tb/tb_hir_vec_add.sv
// ============================================================================
// Module   : tb_hir_vec_add
// Purpose  : Directed self-checking bench for hir_vec_add.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hir_vec_add;

    localparam int N      = 128;
    localparam int ADDR_W = 7;
    localparam int DATA_W = 32;
    localparam int OUT_W  = 64;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              t3  = 1'b0;
    logic [ADDR_W-1:0] v_addr0, v_addr1, v_addr2;
    logic              v_rd_en0, v_rd_en1, v_wr_en2, done;
    logic [DATA_W-1:0] v_rd_data0, v_rd_data1;
    logic [OUT_W-1:0]  v_wr_data2;

    logic [DATA_W-1:0] mem_a [N];
    logic [DATA_W-1:0] mem_b [N];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    hir_vec_add #(.N(N), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .OUT_W(OUT_W)) dut (
        .clk(clk), .rst(rst), .t3(t3),
        .v_addr0(v_addr0), .v_rd_en0(v_rd_en0), .v_rd_data0(v_rd_data0),
        .v_addr1(v_addr1), .v_rd_en1(v_rd_en1), .v_rd_data1(v_rd_data1),
        .v_addr2(v_addr2), .v_wr_en2(v_wr_en2), .v_wr_data2(v_wr_data2),
        .done(done)
    );

    // 1-cycle read latency memories; garbage when not enabled.
    always @(posedge clk) begin
        v_rd_data0 <= v_rd_en0 ? mem_a[v_addr0] : 32'hDEAD_BEEF;
        v_rd_data1 <= v_rd_en1 ? mem_b[v_addr1] : 32'hBAAD_F00D;
    end

    task automatic test_reset();
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            t3 = (k == 1);
            tests++;
            if ({v_rd_en0, v_rd_en1, v_wr_en2, done} !== 4'b0000 ||
                v_addr0 !== '0 || v_addr2 !== '0 || v_wr_data2 !== '0) begin
                fails++;
                $display("FAIL reset: en/done=%b addr0=%0d addr2=%0d data=%h, want all 0",
                         {v_rd_en0, v_rd_en1, v_wr_en2, done}, v_addr0, v_addr2, v_wr_data2);
            end
        end
        @(negedge clk);
        t3  = 1'b0;
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            tests++;
            if ({v_rd_en0, v_rd_en1, v_wr_en2, done} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_idle: en/done=%b want 0000", {v_rd_en0, v_rd_en1, v_wr_en2, done});
            end
        end
    endtask

    task automatic test_basic();
        logic exp_rd, exp_wr;
        logic [ADDR_W-1:0] ea;
        logic [OUT_W-1:0]  ed;
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 32'(5 + i);
            mem_b[i] = 32'(100 + i);
        end
        t3 = 1'b1;
        for (int k = 1; k <= N + 3; k++) begin
            @(negedge clk);
            t3 = 1'b0;
            exp_rd = (k >= 1 && k <= N);
            exp_wr = (k >= 3 && k <= N + 2);
            tests++;
            if (v_rd_en0 !== exp_rd || v_rd_en1 !== exp_rd) begin
                fails++;
                $display("FAIL basic_rd_en k=%0d: got %b%b want %b", k, v_rd_en0, v_rd_en1, exp_rd);
            end
            if (exp_rd) begin
                ea = ADDR_W'(k - 1);
                tests++;
                if (v_addr0 !== ea || v_addr1 !== ea) begin
                    fails++;
                    $display("FAIL basic_rd_addr k=%0d: got %0d/%0d want %0d", k, v_addr0, v_addr1, ea);
                end
            end
            tests++;
            if (v_wr_en2 !== exp_wr) begin
                fails++;
                $display("FAIL basic_wr_en k=%0d: got %b want %b", k, v_wr_en2, exp_wr);
            end
            if (exp_wr) begin
                ea = ADDR_W'(k - 3);
                ed = OUT_W'(105 + 2 * (k - 3));
                tests++;
                if (v_addr2 !== ea || v_wr_data2 !== ed) begin
                    fails++;
                    $display("FAIL basic_write k=%0d: got addr %0d data %0d want addr %0d data %0d",
                             k, v_addr2, v_wr_data2, ea, ed);
                end
            end
            tests++;
            if (done !== (k == N + 3)) begin
                fails++;
                $display("FAIL basic_done k=%0d: got %b want %b", k, done, (k == N + 3));
            end
        end
    endtask

    // Entered in the done cycle of the previous run: start must be taken now.
    task automatic test_back_to_back();
        int nwr = 0, ndone = 0;
        t3 = 1'b1;
        for (int k = 1; k <= N + 4; k++) begin
            @(negedge clk);
            t3 = 1'b0;
            if (k == 1) begin
                tests++;
                if (v_rd_en0 !== 1'b1 || v_addr0 !== '0) begin
                    fails++;
                    $display("FAIL b2b_start: rd_en=%b addr=%0d want 1/0", v_rd_en0, v_addr0);
                end
            end
            if (v_wr_en2 === 1'b1) nwr++;
            if (done === 1'b1) ndone++;
            if (k == N + 2) begin
                tests++;
                if (v_wr_data2 !== 64'd359 || v_addr2 !== ADDR_W'(N - 1)) begin
                    fails++;
                    $display("FAIL b2b_last: got addr %0d data %0d want 127/359", v_addr2, v_wr_data2);
                end
            end
        end
        tests++;
        if (nwr != N || ndone != 1) begin
            fails++;
            $display("FAIL b2b_counts: writes %0d done %0d want %0d/1", nwr, ndone, N);
        end
    endtask

    task automatic test_max();
        int nwr = 0;
        logic [OUT_W-1:0] ed;
`ifdef HIR_VEC_ADD_SIGNED_EN
        ed = 64'hFFFF_FFFF_FFFF_FFFE;
`else
        ed = 64'h0000_0001_FFFF_FFFE;
`endif
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 32'hFFFF_FFFF;
            mem_b[i] = 32'hFFFF_FFFF;
        end
        t3 = 1'b1;
        for (int k = 1; k <= N + 4; k++) begin
            @(negedge clk);
            t3 = 1'b0;
            if (v_wr_en2 === 1'b1) begin
                nwr++;
                tests++;
                if (v_wr_data2 !== ed) begin
                    fails++;
                    $display("FAIL max_data k=%0d: got %h want %h", k, v_wr_data2, ed);
                end
            end
        end
        tests++;
        if (nwr != N) begin
            fails++;
            $display("FAIL max_count: writes %0d want %0d", nwr, N);
        end
    endtask

    task automatic test_retrigger();
        int nwr = 0, ndone = 0, nrd = 0;
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 32'(i);
            mem_b[i] = 32'(1000);
        end
        t3 = 1'b1;
        for (int k = 1; k <= N + 8; k++) begin
            @(negedge clk);
            t3 = (k == 10 || k == 60 || k == N + 1);
            if (v_rd_en0 === 1'b1) nrd++;
            if (v_wr_en2 === 1'b1) nwr++;
            if (done === 1'b1) ndone++;
        end
        t3 = 1'b0;
        tests++;
        if (nrd != N || nwr != N || ndone != 1) begin
            fails++;
            $display("FAIL retrigger: reads %0d writes %0d done %0d want %0d/%0d/1", nrd, nwr, ndone, N, N);
        end
    endtask

    task automatic test_abort_restart();
        int nbad = 0, nwr = 0;
        t3 = 1'b1;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            t3 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        tests++;
        if ({v_rd_en0, v_rd_en1, v_wr_en2, done} !== 4'b0000) begin
            fails++;
            $display("FAIL abort_now: en/done=%b want 0000", {v_rd_en0, v_rd_en1, v_wr_en2, done});
        end
        for (int k = 0; k < N + 10; k++) begin
            @(negedge clk);
            if ({v_rd_en0, v_rd_en1, v_wr_en2, done} !== 4'b0000) nbad++;
        end
        tests++;
        if (nbad != 0) begin
            fails++;
            $display("FAIL abort_quiet: %0d active cycles want 0", nbad);
        end
        for (int i = 0; i < N; i++) begin
            mem_a[i] = 32'(3 * i);
            mem_b[i] = 32'(7);
        end
        t3 = 1'b1;
        for (int k = 1; k <= N + 3; k++) begin
            @(negedge clk);
            t3 = 1'b0;
            if (v_wr_en2 === 1'b1) begin
                nwr++;
                tests++;
                if (v_addr2 !== ADDR_W'(k - 3) || v_wr_data2 !== OUT_W'(3 * (k - 3) + 7)) begin
                    fails++;
                    $display("FAIL restart_write k=%0d: got addr %0d data %0d want addr %0d data %0d",
                             k, v_addr2, v_wr_data2, k - 3, 3 * (k - 3) + 7);
                end
            end
        end
        tests++;
        if (nwr != N || done !== 1'b1) begin
            fails++;
            $display("FAIL restart_end: writes %0d done %b want %0d/1", nwr, done, N);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_max();
        test_retrigger();
        test_abort_restart();
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
